// File: rtl/cnn_layer_sequencer.sv
// Layer scheduler for the CNN accelerator: walks a small per-layer config table,
// programs base address and layer config, pulses layer_start and tracks layer_done.
module cnn_layer_sequencer #(
    parameter int N_LAYER    = 3,
    parameter int Ti         = 16,
    parameter int To         = 16,
    parameter int N          = 16,
    parameter int W_LIDX     = 4,
    parameter int GAP_CYCLES = 128
) (
    input  logic              HCLK,
    input  logic              HRESET,
    input  logic              cfg_we,
    input  logic [W_LIDX-1:0] cfg_idx,
    input  logic [8:0]        cfg_data,
    input  logic [W_LIDX-1:0] n_layers,
    input  logic [31:0]       base_init,
    input  logic              start,
    input  logic              abort,
    input  logic              layer_done,
    output logic [31:0]       base_address,
    output logic [31:0]       layer_config,
    output logic              layer_start,
    output logic [W_LIDX-1:0] cur_layer,
    output logic              busy,
    output logic              seq_done
);
    localparam logic [19:0]       W_STEP_3X3 = 20'(Ti * To * 9 / N);
    localparam logic [19:0]       W_STEP_1X1 = 20'(To);
    localparam logic [11:0]       P_STEP     = 12'(To);
    localparam int                GW         = $clog2(GAP_CYCLES + 1);
    localparam logic [GW-1:0]     GAP_LAST   = GW'(GAP_CYCLES);
    localparam logic [W_LIDX-1:0] NL_MAX     = W_LIDX'(N_LAYER);

    typedef enum logic [2:0] {S_IDLE, S_CONFIG, S_START, S_WAIT, S_GAP, S_DONE} state_t;

    state_t            state_q;
    logic [8:0]        tbl_q [N_LAYER];
    logic              start_q, done_q;
    logic [W_LIDX-1:0] nl_q, cur_q;
    logic [19:0]       wbase_q;
    logic [11:0]       pbase_q;
    logic [GW-1:0]     gap_q;
    logic [31:0]       base_address_q, layer_config_q;
    logic              layer_start_q, busy_q, seq_done_q;

    logic              start_edge, done_edge;
    logic [W_LIDX-1:0] nl_d, next_idx_d;
    logic [8:0]        entry_next;
    logic [31:0]       cfg_first_d, cfg_next_d;
    logic [19:0]       wbase_d;
    logic [11:0]       pbase_d;

    // {16'b0, act, bias, idx, last, conv3x3, last, first}
    function automatic logic [31:0] make_cfg(input logic [8:0] entry,
                                             input logic [W_LIDX-1:0] idx,
                                             input logic [W_LIDX-1:0] nl);
        logic first, last;
        first = (idx == '0);
        last  = (idx == nl - W_LIDX'(1));
        return {16'b0, entry[8:6], entry[5:1], 4'(idx), last, entry[0], last, first};
    endfunction

    always_comb begin
        start_edge = start & ~start_q;
        done_edge  = layer_done & ~done_q;
        nl_d       = (n_layers > NL_MAX) ? NL_MAX : n_layers;
        next_idx_d = cur_q + W_LIDX'(1);
        entry_next = '0;
        for (int i = 0; i < N_LAYER; i++)
            if (next_idx_d == W_LIDX'(i)) entry_next = tbl_q[i];
        cfg_first_d = make_cfg(tbl_q[0], '0, nl_d);
        cfg_next_d  = make_cfg(entry_next, next_idx_d, nl_q);
        wbase_d     = wbase_q + (layer_config_q[2] ? W_STEP_3X3 : W_STEP_1X1);
        pbase_d     = pbase_q + P_STEP;
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q        <= S_IDLE;
            for (int i = 0; i < N_LAYER; i++) tbl_q[i] <= '0;
            start_q        <= 1'b0;
            done_q         <= 1'b0;
            nl_q           <= '0;
            cur_q          <= '0;
            wbase_q        <= '0;
            pbase_q        <= '0;
            gap_q          <= '0;
            base_address_q <= '0;
            layer_config_q <= '0;
            layer_start_q  <= 1'b0;
            busy_q         <= 1'b0;
            seq_done_q     <= 1'b0;
        end else begin
            start_q       <= start;
            done_q        <= layer_done;
            layer_start_q <= 1'b0;
            seq_done_q    <= 1'b0;
            for (int i = 0; i < N_LAYER; i++)
                if (cfg_we && !busy_q && cfg_idx == W_LIDX'(i)) tbl_q[i] <= cfg_data;

            if (abort) begin
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: if (start_edge) begin
                        nl_q    <= nl_d;
                        wbase_q <= base_init[19:0];
                        pbase_q <= base_init[31:20];
                        cur_q   <= '0;
                        if (nl_d == '0) begin
                            state_q    <= S_DONE;
                            seq_done_q <= 1'b1;
                        end else begin
                            // outputs load on CONFIG entry so they lead the start pulse
                            state_q        <= S_CONFIG;
                            busy_q         <= 1'b1;
                            base_address_q <= base_init;
                            layer_config_q <= cfg_first_d;
                        end
                    end
                    S_CONFIG: begin
                        state_q       <= S_START;
                        layer_start_q <= 1'b1;
                    end
                    S_START: state_q <= S_WAIT;
                    S_WAIT: if (done_edge) begin
                        wbase_q <= wbase_d;
                        pbase_q <= pbase_d;
                        gap_q   <= '0;
                        if (layer_config_q[1]) begin
                            state_q    <= S_DONE;
                            seq_done_q <= 1'b1;
                            busy_q     <= 1'b0;
                        end else begin
                            state_q <= S_GAP;
                        end
                    end
                    S_GAP: if (gap_q == GAP_LAST) begin
                        cur_q          <= next_idx_d;
                        base_address_q <= {pbase_q, wbase_q};
                        layer_config_q <= cfg_next_d;
                        state_q        <= S_CONFIG;
                    end else begin
                        gap_q <= gap_q + GW'(1);
                    end
                    S_DONE:  state_q <= S_IDLE;
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign base_address = base_address_q;
    assign layer_config = layer_config_q;
    assign layer_start  = layer_start_q;
    assign cur_layer    = cur_q;
    assign busy         = busy_q;
    assign seq_done     = seq_done_q;
endmodule
